// File: rtl/eth_bd_arb_pkg.sv
// Shared definitions for the Ethernet buffer-descriptor RAM arbiter:
// requester indices, FSM state type, field widths and index helpers.
package eth_bd_arb_pkg;

  localparam int NUM_REQ    = 3;
  localparam int BE_W       = 4;
  localparam int LOCK_CNT_W = 4;

  typedef logic [1:0]            req_idx_t;
  typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

  localparam req_idx_t REQ_HOST = 2'd0;
  localparam req_idx_t REQ_TX   = 2'd1;
  localparam req_idx_t REQ_RX   = 2'd2;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Requester that follows i in round-robin order (RX wraps to host).
  function automatic req_idx_t next_idx(input req_idx_t i);
    return (i >= REQ_RX) ? REQ_HOST : i + 2'd1;
  endfunction

  function automatic req_idx_t onehot_idx(input logic [NUM_REQ-1:0] oh);
    if (oh[REQ_RX]) return REQ_RX;
    if (oh[REQ_TX]) return REQ_TX;
    return REQ_HOST;
  endfunction

endpackage

// File: rtl/eth_rr_arb3.sv
// Three-way round-robin picker: grants the first asserted request found
// when searching upward from ptr, wrapping RX back to host.
module eth_rr_arb3
  import eth_bd_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] gnt
);

  req_idx_t idx;
  logic     found;

  // An out-of-range pointer is treated as host so the search always starts on a real requester.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = (ptr > REQ_RX) ? REQ_HOST : ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/eth_bd_ram_arb.sv
// Buffer-descriptor RAM arbiter for host, TX and RX with optional burst locking.
// Define ETH_BD_ARB_HOST_PRIO_EN to give the host strict priority while arbitrating.
module eth_bd_ram_arb
  import eth_bd_arb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      lock,
  input  logic [NUM_REQ*BE_W-1:0] we,
  input  logic [NUM_REQ*AW-1:0]   addr,
  input  logic [NUM_REQ*DW-1:0]   wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rvalid,
  output logic [DW-1:0]           rdata,
  output logic                    ram_ce,
  output logic [BE_W-1:0]         ram_we,
  output logic                    ram_oe,
  output logic [AW-1:0]           ram_addr,
  output logic [DW-1:0]           ram_di,
  input  logic [DW-1:0]           ram_dout
);

  localparam lock_cnt_t LOCK_LIMIT = lock_cnt_t'(LOCK_MAX);

  arb_state_t          state_q, state_d;
  req_idx_t            ptr_q, ptr_d;
  req_idx_t            owner_q, owner_d;
  lock_cnt_t           cnt_q, cnt_d;
  lock_cnt_t           cnt_inc;
  logic [NUM_REQ-1:0]  rr_req, rr_gnt;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       di_q;
  logic [BE_W-1:0]     we_arr   [NUM_REQ];
  logic [AW-1:0]       addr_arr [NUM_REQ];
  logic [DW-1:0]       di_arr   [NUM_REQ];
  logic                gnt_any;
  logic                rd_gnt;
  req_idx_t            gnt_idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      we_arr[i]   = we[i*BE_W +: BE_W];
      addr_arr[i] = addr[i*AW +: AW];
      di_arr[i]   = wdata[i*DW +: DW];
    end
  end

`ifdef ETH_BD_ARB_HOST_PRIO_EN
  // Host wins outright; TX and RX only rotate when the host is quiet.
  assign rr_req = req[REQ_HOST] ? 3'b001 : (req & 3'b110);
`else
  assign rr_req = req;
`endif

  eth_rr_arb3 u_rr (
    .req (rr_req),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= REQ_HOST;
      owner_q <= REQ_HOST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_any = |gnt;
  assign gnt_idx = onehot_idx(gnt);
  assign cnt_inc = cnt_q + lock_cnt_t'(1);

  // Every grant moves the pointer past the winner, so a released owner goes to the back.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (gnt_any) begin
      ptr_d = next_idx(gnt_idx);
      case (state_q)
        ST_ARB: begin
          if (lock[gnt_idx] && (LOCK_MAX > 1)) begin
            state_d = ST_LOCKED;
            owner_d = gnt_idx;
            cnt_d   = lock_cnt_t'(1);
          end
        end
        ST_LOCKED: begin
          if (!lock[owner_q] || (cnt_inc >= LOCK_LIMIT)) begin
            state_d = ST_ARB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  // Grants are combinational from req, so they are masked directly while reset is held.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (state_q == ST_LOCKED) begin
        if (req[owner_q]) gnt[owner_q] = 1'b1;
      end else begin
        gnt = rr_gnt;
      end
    end
  end

  always_comb begin
    rd_gnt   = gnt_any && (we_arr[gnt_idx] == '0);
    ram_we   = gnt_any ? we_arr[gnt_idx]   : '0;
    ram_addr = gnt_any ? addr_arr[gnt_idx] : addr_q;
    ram_di   = gnt_any ? di_arr[gnt_idx]   : di_q;
    ram_oe   = |rvalid_q;
    ram_ce   = gnt_any || ram_oe;
    rdata    = ram_oe ? ram_dout : '0;
  end

  assign rvalid = rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      addr_q   <= '0;
      di_q     <= '0;
    end else begin
      rvalid_q <= rd_gnt ? gnt : '0;
      addr_q   <= ram_addr;
      di_q     <= ram_di;
    end
  end

endmodule

// File: tb/tb_eth_bd_ram_arb.sv
// Directed bench for eth_bd_ram_arb with a byte-writable synchronous RAM model;
// expected grant order follows ETH_BD_ARB_HOST_PRIO_EN when it is defined.
module tb_eth_bd_ram_arb;

  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 4;

`ifdef ETH_BD_ARB_HOST_PRIO_EN
  localparam logic [2:0] RR_SEQ [4] = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
  localparam logic [2:0] RR_SEQ [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif

  localparam logic [2:0] LK_REQ [8] = '{3'b100, 3'b101, 3'b101, 3'b101,
                                        3'b101, 3'b100, 3'b001, 3'b101};
  localparam logic [2:0] LK_GNT [8] = '{3'b100, 3'b100, 3'b100, 3'b100,
                                        3'b001, 3'b100, 3'b000, 3'b100};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      req = '0;
  logic [2:0]      lock = '0;
  logic [11:0]     we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_ce, ram_oe;
  logic [3:0]      ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_di;
  logic [DW-1:0]   ram_dout;

  logic [DW-1:0]   mem [256];
  logic            load_en = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [DW-1:0]   load_data = '0;

  int checkCount = 0;
  int passCount  = 0;

  eth_bd_ram_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registered read of the addressed word on every enabled edge.
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l);
    req  = r;
    lock = l;
    #3;
  endtask

  task automatic setPort(input int idx, input logic [3:0] w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[idx*4 +: 4]     = w;
    addr[idx*AW +: AW] = a;
    wdata[idx*DW +: DW] = d;
  endtask

  task automatic loadWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
    nextCycle();
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
  endtask

  function automatic logic [AW-1:0] addrOf(input logic [2:0] g);
    case (g)
      3'b001:  return 8'h10;
      3'b010:  return 8'h20;
      default: return 8'h30;
    endcase
  endfunction

  function automatic logic [DW-1:0] wordOf(input logic [2:0] g);
    case (g)
      3'b001:  return 32'h1111_0010;
      3'b010:  return 32'h2222_0020;
      default: return 32'h3333_0030;
    endcase
  endfunction

  // Four cycles of req=111 reads, then two idle cycles.
  task automatic runRoundRobin();
    logic [2:0] exp_g, prev_g;
    prev_g = '0;
    setPort(0, 4'h0, 8'h10, '0);
    setPort(1, 4'h0, 8'h20, '0);
    setPort(2, 4'h0, 8'h30, '0);
    for (int c = 0; c < 6; c++) begin
      nextCycle();
      applyStimulus((c < 4) ? 3'b111 : 3'b000, 3'b000);
      exp_g = (c < 4) ? RR_SEQ[c] : 3'b000;
      checkOutput("rr_gnt", {29'd0, gnt}, {29'd0, exp_g});
      if (exp_g != '0) checkOutput("rr_addr", {24'd0, ram_addr}, {24'd0, addrOf(exp_g)});
      checkOutput("rr_rvalid", {29'd0, rvalid}, {29'd0, prev_g});
      if (prev_g != '0) checkOutput("rr_rdata", rdata, wordOf(prev_g));
      if (c == 4) begin
        checkOutput("idle_ce", {31'd0, ram_ce}, 32'd1);
        checkOutput("idle_oe", {31'd0, ram_oe}, 32'd1);
        checkOutput("idle_we", {28'd0, ram_we}, 32'd0);
      end
      if (c == 5) begin
        checkOutput("quiet_ce", {31'd0, ram_ce}, 32'd0);
        checkOutput("quiet_oe", {31'd0, ram_oe}, 32'd0);
        checkOutput("hold_addr", {24'd0, ram_addr}, {24'd0, addrOf(RR_SEQ[3])});
      end
      prev_g = exp_g;
    end
  endtask

  initial begin
    logic [2:0] prev_g;

    rst_n = 1'b0;
    req   = 3'b111;
    #3;
    checkOutput("rst_gnt", {29'd0, gnt}, 32'd0);
    checkOutput("rst_ce", {31'd0, ram_ce}, 32'd0);
    checkOutput("rst_addr", {24'd0, ram_addr}, 32'd0);
    req = 3'b000;
    loadWord(8'h10, 32'h1111_0010);
    loadWord(8'h20, 32'h2222_0020);
    loadWord(8'h30, 32'h3333_0030);
    loadWord(8'h05, 32'h1122_3344);
    nextCycle();
    load_en = 1'b0;

    nextCycle();
    rst_n = 1'b1;
    applyStimulus(3'b000, 3'b000);
    checkOutput("rel_rvalid", {29'd0, rvalid}, 32'd0);
    runRoundRobin();

    // Partial byte write followed by a read-back of the merged word.
    nextCycle();
    setPort(0, 4'b0011, 8'h05, 32'hAABB_CCDD);
    applyStimulus(3'b001, 3'b000);
    checkOutput("wr_gnt", {29'd0, gnt}, 32'h1);
    checkOutput("wr_we", {28'd0, ram_we}, 32'h3);
    checkOutput("wr_di", ram_di, 32'hAABB_CCDD);
    checkOutput("wr_addr", {24'd0, ram_addr}, 32'h05);
    nextCycle();
    setPort(0, 4'b0000, 8'h05, '0);
    applyStimulus(3'b001, 3'b000);
    checkOutput("rd_gnt", {29'd0, gnt}, 32'h1);
    checkOutput("wr_no_rvalid", {29'd0, rvalid}, 32'd0);
    nextCycle();
    applyStimulus(3'b000, 3'b000);
    checkOutput("rd_rvalid", {29'd0, rvalid}, 32'h1);
    checkOutput("rd_merge", rdata, 32'h1122_CCDD);

    // RX burst lock with the host waiting; owner idle in the last locked cycle.
    setPort(0, 4'h0, 8'h10, '0);
    setPort(2, 4'h0, 8'h30, '0);
    prev_g = '0;
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      applyStimulus(LK_REQ[c], 3'b100);
      checkOutput("lk_gnt", {29'd0, gnt}, {29'd0, LK_GNT[c]});
      checkOutput("lk_rvalid", {29'd0, rvalid}, {29'd0, prev_g});
      if (prev_g != '0) checkOutput("lk_rdata", rdata, wordOf(prev_g));
      prev_g = LK_GNT[c];
    end

    // Reset while locked with a read just granted.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_gnt", {29'd0, gnt}, 32'd0);
    checkOutput("arst_ce", {31'd0, ram_ce}, 32'd0);
    checkOutput("arst_oe", {31'd0, ram_oe}, 32'd0);
    checkOutput("arst_we", {28'd0, ram_we}, 32'd0);
    checkOutput("arst_addr", {24'd0, ram_addr}, 32'd0);
    checkOutput("arst_rdata", rdata, 32'd0);
    nextCycle();
    checkOutput("arst_pending", {29'd0, rvalid}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(3'b000, 3'b000);
    checkOutput("arst_rel_rvalid", {29'd0, rvalid}, 32'd0);
    runRoundRobin();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, %0d/%0d passed", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
